or_hit_monitor: RTL

- Downstream consumer of the pipelined OR-reduction tree: takes the tree's registered `out` bit and turns it into software-visible event state.
- Delays the sample-valid strobe that entered the tree by the tree's latency, so `or_in` is only qualified on real samples.
- Keeps a sticky hit flag, a saturating hit count, the sample index of the first hit, and a one-cycle first-hit pulse.
- A req/ack handshake clears the state.

---
 rtl/or_hit_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/or_hit_monitor.sv
// Hit monitor behind the pipelined OR-reduction tree: aligns in_valid to the tree latency and
// keeps sticky/pulse/count/first-index event state with a req/ack clear. Optional: OR_HIT_MON_OVF_EN.
module or_hit_monitor #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             or_in,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic             hit_sticky,
  output logic             hit_pulse,
  output logic [CNT_W-1:0] hit_count,
  output logic [TS_W-1:0]  first_ts
`ifdef OR_HIT_MON_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Each tree stage reduces up to 6 inputs and adds one register.
  function automatic int unsigned calc_lat(input int unsigned w);
    int unsigned l;
    int unsigned r;
    l = 1;
    r = w;
    while (r > 6) begin
      r = (r + 5) / 6;
      l++;
    end
    return l;
  endfunction

  localparam int unsigned LAT = calc_lat(WIDTH);

  typedef enum logic {C_IDLE, C_ACK} clr_state_t;

  clr_state_t       state;
  logic [LAT-1:0]   dly;
  logic [TS_W-1:0]  ts;
  logic             v_al;
  logic             hit;
  logic             clr_start;
  logic             base_sticky;
  logic [CNT_W-1:0] base_count;

  assign v_al      = dly[LAT-1];
  assign hit       = v_al & or_in;
  assign clr_start = (state == C_IDLE) && clr_req;

  // A clear landing with a hit is applied first; the hit then counts as the first post-clear event.
  always_comb begin
    base_sticky = hit_sticky;
    base_count  = hit_count;
    if (clr_start) begin
      base_sticky = 1'b0;
      base_count  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly <= '0;
      ts  <= '0;
    end else begin
      dly[0] <= in_valid;
      for (int unsigned i = 1; i < LAT; i++) dly[i] <= dly[i-1];
      if (v_al) ts <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= C_IDLE;
      clr_ack <= 1'b0;
    end else begin
      case (state)
        C_IDLE: if (clr_req) begin
          state   <= C_ACK;
          clr_ack <= 1'b1;
        end
        C_ACK: if (!clr_req) begin
          state   <= C_IDLE;
          clr_ack <= 1'b0;
        end
        default: begin
          state   <= C_IDLE;
          clr_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_sticky <= 1'b0;
      hit_pulse  <= 1'b0;
      hit_count  <= '0;
      first_ts   <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      hit_sticky <= base_sticky;
      hit_count  <= base_count;
      if (clr_start) first_ts <= '0;
      if (hit) begin
        if (base_count != '1) hit_count <= base_count + CNT_W'(1);
        if (!base_sticky) begin
          hit_sticky <= 1'b1;
          hit_pulse  <= 1'b1;
          first_ts   <= ts;
        end
      end
    end
  end

`ifdef OR_HIT_MON_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= (ovf & ~clr_start) | (hit & (base_count == '1));
  end
`endif

endmodule
